// File: rtl/draw_rect_pkg.sv
// Shared types and geometry defaults for the falling-rectangle controller.
package draw_rect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FALL,
        ST_BOUNCE,
        ST_STOP
    } state_t;

    localparam int DEF_SCREEN_HEIGHT = 600;
    localparam int DEF_RECT_HEIGHT   = 64;
    localparam int DEF_V_MAX         = 16;

    // Lowest Y at which the rectangle still fits entirely on screen.
    function automatic logic [11:0] floor_y(input int screen_h, input int rect_h);
        return 12'(screen_h - rect_h);
    endfunction

endpackage

// File: rtl/edge_det.sv
// Single-cycle rising-edge pulse for a level that is already synchronous to clk.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/draw_rect_ctl.sv
// Rectangle follows the mouse until clicked, then falls under gravity once per frame.
// Define DRAW_RECT_CTL_BOUNCE_EN to let impacts rebound at half speed instead of stopping.
module draw_rect_ctl
    import draw_rect_pkg::*;
#(
    parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
    parameter int RECT_HEIGHT   = DEF_RECT_HEIGHT,
    parameter int V_MAX         = DEF_V_MAX
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    input  logic        vsync_in,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        busy
);

    localparam logic [12:0] FLOOR13 = {1'b0, floor_y(SCREEN_HEIGHT, RECT_HEIGHT)};
    localparam logic [5:0]  VMAX6   = 6'(V_MAX);

    logic        tick;
    logic        click;

    state_t      state_q, state_d;
    logic [11:0] xpos_q, xpos_d;
    logic [11:0] ypos_q, ypos_d;
    logic [4:0]  vel_q, vel_d;

    logic [5:0]  vel_inc;
    logic [5:0]  v1;
    logic [12:0] fall_sum;
`ifdef DRAW_RECT_CTL_BOUNCE_EN
    logic [12:0] rise_diff;
`endif

    edge_det u_tick_det (
        .clk    (pclk),
        .rst    (rst),
        .sig_i  (vsync_in),
        .rise_o (tick)
    );

    edge_det u_click_det (
        .clk    (pclk),
        .rst    (rst),
        .sig_i  (mouse_left),
        .rise_o (click)
    );

    // Arithmetic is one bit wider than ypos so the floor compare sees true sums.
    assign vel_inc  = {1'b0, vel_q} + 6'd1;
    assign v1       = (vel_inc > VMAX6) ? VMAX6 : vel_inc;
    assign fall_sum = {1'b0, ypos_q} + {7'd0, v1};
`ifdef DRAW_RECT_CTL_BOUNCE_EN
    assign rise_diff = {1'b0, ypos_q} - {8'd0, vel_q};
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;
        vel_d   = vel_q;

        unique case (state_q)
            ST_IDLE: begin
                if (click) begin
                    state_d = ST_FALL;
                    vel_d   = 5'd0;
                end else begin
                    xpos_d = mouse_xpos;
                    ypos_d = ({1'b0, mouse_ypos} > FLOOR13) ? FLOOR13[11:0] : mouse_ypos;
                end
            end

            ST_FALL: begin
                if (tick) begin
                    if (fall_sum >= FLOOR13) begin
                        ypos_d = FLOOR13[11:0];
`ifdef DRAW_RECT_CTL_BOUNCE_EN
                        if (v1[5:1] != 5'd0) begin
                            state_d = ST_BOUNCE;
                            vel_d   = v1[5:1];
                        end else begin
                            state_d = ST_STOP;
                            vel_d   = 5'd0;
                        end
`else
                        state_d = ST_STOP;
                        vel_d   = 5'd0;
`endif
                    end else begin
                        ypos_d = fall_sum[11:0];
                        vel_d  = v1[4:0];
                    end
                end
            end

`ifdef DRAW_RECT_CTL_BOUNCE_EN
            ST_BOUNCE: begin
                if (tick) begin
                    ypos_d = rise_diff[12] ? 12'd0 : rise_diff[11:0];
                    if (vel_q == 5'd1) begin
                        state_d = ST_FALL;
                        vel_d   = 5'd0;
                    end else begin
                        vel_d = vel_q - 5'd1;
                    end
                end
            end
`endif

            ST_STOP: begin
                ypos_d = FLOOR13[11:0];
                if (click) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            xpos_q  <= 12'd0;
            ypos_q  <= 12'd0;
            vel_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            vel_q   <= vel_d;
        end
    end

    assign xpos = xpos_q;
    assign ypos = ypos_q;
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Directed bench for draw_rect_ctl; a trajectory-planning model is compared every cycle.
module tb_draw_rect_ctl;

    localparam int FLOOR = 536;
    localparam int VMAX  = 16;
`ifdef DRAW_RECT_CTL_BOUNCE_EN
    localparam bit BOUNCE = 1'b1;
`else
    localparam bit BOUNCE = 1'b0;
`endif

    logic        pclk;
    logic        rst;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        mouse_left;
    logic        vsync_in;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    draw_rect_ctl dut (
        .pclk       (pclk),
        .rst        (rst),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .mouse_left (mouse_left),
        .vsync_in   (vsync_in),
        .xpos       (xpos),
        .ypos       (ypos),
        .busy       (busy)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: on a click the whole flight is planned as a list of per-frame Y positions.
    localparam int M_IDLE = 0, M_MOVING = 1, M_STOP = 2;

    logic        s_rst, s_vs, s_ml;
    logic [11:0] s_mx, s_my;
    int          m_mode;
    int          m_x, m_y;
    bit          m_vs, m_ml, m_valid;
    int          traj[$];

    always @(posedge pclk) begin
        s_rst <= rst;
        s_vs  <= vsync_in;
        s_ml  <= mouse_left;
        s_mx  <= mouse_xpos;
        s_my  <= mouse_ypos;
    end

    function automatic void plan_flight(input int y0);
        int y = y0;
        int v = 0;
        int step;
        int half;
        traj.delete();
        while (1) begin
            step = (v + 1 > VMAX) ? VMAX : v + 1;
            if (y + step >= FLOOR) begin
                y = FLOOR;
                traj.push_back(y);
                half = BOUNCE ? step / 2 : 0;
                if (half == 0) break;
                for (int d = half; d >= 1; d--) begin
                    y = (y - d < 0) ? 0 : y - d;
                    traj.push_back(y);
                end
                v = 0;
            end else begin
                y = y + step;
                v = step;
                traj.push_back(y);
            end
        end
    endfunction

    task automatic model_step();
        bit tick, click;
        if (s_rst === 1'b1) begin
            m_mode  = M_IDLE;
            m_x     = 0;
            m_y     = 0;
            m_vs    = 1'b0;
            m_ml    = 1'b0;
            m_valid = 1'b1;
            traj.delete();
        end else if (m_valid) begin
            tick  = s_vs && !m_vs;
            click = s_ml && !m_ml;
            m_vs  = s_vs;
            m_ml  = s_ml;
            case (m_mode)
                M_IDLE: begin
                    if (click) begin
                        m_mode = M_MOVING;
                        plan_flight(m_y);
                    end else begin
                        m_x = int'(s_mx);
                        m_y = (int'(s_my) > FLOOR) ? FLOOR : int'(s_my);
                    end
                end
                M_MOVING: begin
                    if (tick) begin
                        m_y = traj.pop_front();
                        if (traj.size() == 0) m_mode = M_STOP;
                    end
                end
                default: begin
                    if (click) m_mode = M_IDLE;
                end
            endcase
        end
    endtask

    always @(negedge pclk) begin
        model_step();
        if (m_valid) begin
            check("model_xpos", int'(xpos), m_x);
            check("model_ypos", int'(ypos), m_y);
            check("model_busy", int'(busy), (m_mode != M_IDLE) ? 1 : 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic pulse_tick();
        vsync_in = 1'b1;
        cyc(1);
        vsync_in = 1'b0;
        cyc(1);
    endtask

    task automatic pulse_click();
        mouse_left = 1'b1;
        cyc(1);
        mouse_left = 1'b0;
        cyc(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        mouse_xpos = 12'd100;
        mouse_ypos = 12'd700;
        mouse_left = 1'b0;
        vsync_in   = 1'b0;
        cyc(2);
        check("reset_xpos", int'(xpos), 0);
        check("reset_ypos", int'(ypos), 0);
        check("reset_busy", int'(busy), 0);

        rst = 1'b0;
        cyc(1);
        check("idle_clamp_ypos", int'(ypos), 536);
        check("idle_xpos", int'(xpos), 100);
        check("idle_busy", int'(busy), 0);

        mouse_ypos = 12'd537;
        cyc(1);
        check("idle_floor_plus1", int'(ypos), 536);
        mouse_ypos = 12'd535;
        cyc(1);
        check("idle_floor_minus1", int'(ypos), 535);

        // Click and frame tick together: enter FALL without moving.
        mouse_xpos = 12'd40;
        mouse_ypos = 12'd0;
        cyc(1);
        vsync_in   = 1'b1;
        mouse_left = 1'b1;
        cyc(1);
        vsync_in   = 1'b0;
        mouse_left = 1'b0;
        mouse_xpos = 12'd999;
        mouse_ypos = 12'd400;
        cyc(1);
        check("click_tick_ypos", int'(ypos), 0);
        check("click_xpos_frozen", int'(xpos), 40);
        check("click_busy", int'(busy), 1);

        pulse_tick();
        check("fall_1", int'(ypos), 1);
        pulse_tick();
        check("fall_2", int'(ypos), 3);
        pulse_tick();
        check("fall_3", int'(ypos), 6);
        check("fall_busy", int'(busy), 1);

        pulse_click();
        check("fall_click_ignored", int'(ypos), 6);
        check("fall_click_busy", int'(busy), 1);

        repeat (13) pulse_tick();
        check("fall_vmax_reached", int'(ypos), 136);
        repeat (24) pulse_tick();
        check("fall_capped_steps", int'(ypos), 520);
        pulse_tick();
        check("impact_floor", int'(ypos), 536);
        pulse_tick();
        check("after_impact", int'(ypos), BOUNCE ? 528 : 536);
        check("after_impact_busy", int'(busy), 1);
        check("xpos_held", int'(xpos), 40);

        repeat (40) pulse_tick();
        check("stop_ypos", int'(ypos), 536);
        check("stop_busy", int'(busy), 1);

        mouse_xpos = 12'd321;
        mouse_ypos = 12'd77;
        pulse_click();
        check("rearm_xpos", int'(xpos), 321);
        check("rearm_ypos", int'(ypos), 77);
        check("rearm_busy", int'(busy), 0);

        // Reset in the middle of a fall: 245 + (1+2+...+10) = 300.
        mouse_ypos = 12'd245;
        cyc(1);
        pulse_click();
        repeat (10) pulse_tick();
        check("midfall_ypos", int'(ypos), 300);
        rst = 1'b1;
        cyc(1);
        check("midfall_rst_xpos", int'(xpos), 0);
        check("midfall_rst_ypos", int'(ypos), 0);
        check("midfall_rst_busy", int'(busy), 0);
        rst        = 1'b0;
        mouse_xpos = 12'd5;
        mouse_ypos = 12'd6;
        cyc(1);
        check("post_rst_xpos", int'(xpos), 5);
        check("post_rst_ypos", int'(ypos), 6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/draw_rect_ctl.md
DRAW_RECT_CTL -- requirements
Module: draw_rect_ctl

Interface
REQ-001 Parameters SHALL be: SCREEN_HEIGHT, default 600, visible lines; RECT_HEIGHT, default 64, rectangle height; V_MAX, default 16, velocity cap in lines/frame.
REQ-002 Port pclk  input  1  pixel clock; the only clock.
REQ-003 Port rst  input  1  reset, synchronous and active-high.
REQ-004 Port mouse_xpos  input  12  mouse X position.
REQ-005 Port mouse_ypos  input  12  mouse Y position.
REQ-006 Port mouse_left  input  1  left button level, synchronous to pclk.
REQ-007 Port vsync_in  input  1  VGA vsync; its rising edge is the frame tick.
REQ-008 Port xpos  output  12  rectangle X, registered, consumed by draw_rect.
REQ-009 Port ypos  output  12  rectangle Y, registered, consumed by draw_rect.
REQ-010 Port busy  output  1  high in any state other than IDLE.

Function
REQ-011 FLOOR SHALL equal SCREEN_HEIGHT - RECT_HEIGHT (536 at defaults).
REQ-012 Frame tick SHALL be a 1-cycle pulse when vsync_in is high and its 1-cycle-delayed copy is low; click SHALL be the same rising-edge detection on mouse_left.
REQ-013 States SHALL be IDLE, FALL, BOUNCE and STOP; vel SHALL be an unsigned 5-bit register.
REQ-014 IDLE: every cycle, xpos <= mouse_xpos and ypos <= min(mouse_ypos, FLOOR), so outputs lag the inputs by 1 cycle.
REQ-015 IDLE + click: go to FALL with vel <= 0 and xpos/ypos frozen; a tick in the same cycle SHALL NOT cause a fall step.
REQ-016 FALL + tick: compute v1 = min(vel+1, V_MAX); if ypos+v1 >= FLOOR, set ypos <= FLOOR and take the impact transition (REQ-022); otherwise set ypos <= ypos+v1 and vel <= v1.
REQ-017 BOUNCE + tick: ypos <= max(ypos-vel, 0) and vel <= vel-1; if vel is 1 before the update, go to FALL with vel <= 0.
REQ-018 STOP: ypos SHALL hold at FLOOR; on click, go to IDLE.
REQ-019 mouse_left, mouse_xpos and mouse_ypos SHALL be ignored in FALL and BOUNCE; xpos SHALL be constant outside IDLE.
REQ-020 All sums SHALL be computed 13 bits wide before comparison, so ypos never wraps.

Reset
REQ-021 When rst is high at a pclk edge: xpos=0, ypos=0, busy=0, vel=0, state=IDLE, and both edge-detect history bits=0. This SHALL take effect from any state, including mid-fall.

Configuration
REQ-022 Macro DRAW_RECT_CTL_BOUNCE_EN: when defined, an impact with v1>>1 nonzero goes to BOUNCE with vel <= v1>>1, and otherwise goes to STOP. When undefined, every impact goes to STOP, and BOUNCE SHALL be unreachable and may be omitted.

Structure
REQ-023 Package draw_rect_pkg SHALL hold the state enum, the default SCREEN_HEIGHT/RECT_HEIGHT/V_MAX values and the FLOOR function; draw_rect_ctl SHALL use it.
REQ-024 The rising-edge detector SHALL be one sub-module, edge_det, instantiated twice (vsync_in and mouse_left).

Verification
REQ-025 IDLE, mouse_ypos=700, mouse_xpos=100 -> ypos=536, xpos=100 one cycle later; busy=0.
REQ-026 Click at ypos=0, then 3 ticks -> ypos 1, 3, 6 and busy=1; click during the fall -> no effect.
REQ-027 Fall from ypos=0 until vel=16 -> each later step adds exactly 16; ypos reaches 536 and does not exceed it.
REQ-028 With BOUNCE_EN, impact at v1=16 -> BOUNCE with vel=8; ypos drops by 8, 7, ..., 1, then FALL resumes. Without BOUNCE_EN -> STOP at 536.
REQ-029 In STOP, click -> IDLE; outputs track the mouse again on the next cycle and busy=0.
REQ-030 rst asserted mid-FALL at ypos=300 -> next cycle xpos=0, ypos=0, busy=0, state IDLE.
